// File: rtl/instruction_fetch.sv
// instruction_fetch: two-state fetch/exec front end for ProgramMemory.
// Owns the 4-bit PC, latches the returned instruction into IR, accepts
// jump requests from execute and counts retired instructions.
// Optional macro INSTRUCTION_FETCH_SINGLE_STEP_EN adds a STEP input; when it
// is defined, EXEC completes only on a STEP rising edge.
module instruction_fetch #(
  parameter int         RETIRE_W = 8,
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic                CLK,
  input  logic                RST,
  output logic [3:0]          MEM_ADDR,
  input  logic [7:0]          MEM_DATA,
  input  logic                STALL,
  input  logic                JUMP_EN,
  input  logic [3:0]          JUMP_ADDR,
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
  input  logic                STEP,
`endif
  output logic [7:0]          IR,
  output logic                IR_VALID,
  output logic [3:0]          PC,
  output logic [RETIRE_W-1:0] RETIRED
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t state;
  logic   complete;

`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
  logic step_q;
  logic step_pulse;

  // Previous STEP level; resets high so a button held through reset is not a step.
  always_ff @(posedge CLK) begin
    if (RST) step_q <= 1'b1;
    else     step_q <= STEP;
  end

  assign step_pulse = STEP & ~step_q;

  // EXEC completes only on an unstalled step edge; unused edges are dropped.
  always_comb begin
    complete = ~STALL & step_pulse;
  end
`else
  // EXEC completes on any unstalled cycle.
  always_comb begin
    complete = ~STALL;
  end
`endif

  // Memory address comes straight from the registered PC.
  assign MEM_ADDR = PC;

  // Fetch/exec sequencing with PC, IR, valid flag and retire counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_FETCH;
      PC       <= RESET_PC;
      IR       <= 8'h00;
      IR_VALID <= 1'b0;
      RETIRED  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!STALL) begin
            IR       <= MEM_DATA;
            IR_VALID <= 1'b1;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (complete) begin
            PC       <= JUMP_EN ? JUMP_ADDR : PC + 4'd1;
            RETIRED  <= RETIRED + {{(RETIRE_W-1){1'b0}}, 1'b1};
            IR_VALID <= 1'b0;
            state    <= S_FETCH;
          end
        end
        default: begin
          state    <= S_FETCH;
          IR_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus a randomized run
// checked against an instruction-level reference model.
module tb_instruction_fetch;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] MEM_ADDR;
  logic [7:0] MEM_DATA;
  logic       STALL;
  logic       JUMP_EN;
  logic [3:0] JUMP_ADDR;
  logic       STEP;
  logic [7:0] IR;
  logic       IR_VALID;
  logic [3:0] PC;
  logic [7:0] RETIRED;

  logic [7:0] mem [16];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // model state: next instruction address, fetched instruction, waiting flag
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  logic       m_valid;
  logic [7:0] m_ret;
  logic       m_step_prev = 1'b1;

  always #5 CLK = ~CLK;

  assign MEM_DATA = mem[MEM_ADDR];

  instruction_fetch #(.RETIRE_W(8), .RESET_PC(4'h0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA  (MEM_DATA),
    .STALL     (STALL),
    .JUMP_EN   (JUMP_EN),
    .JUMP_ADDR (JUMP_ADDR),
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
    .STEP      (STEP),
`endif
    .IR        (IR),
    .IR_VALID  (IR_VALID),
    .PC        (PC),
    .RETIRED   (RETIRED)
  );

  // Reference: an instruction is fetched when not waiting and not stalled,
  // then retired on the next permitted cycle, moving to the jump target or
  // the next sequential address.
  task automatic model_edge();
    logic allowed;
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
    allowed = STEP && !m_step_prev;
`else
    allowed = 1'b1;
`endif
    if (RST) begin
      m_pc = 4'h0; m_ir = 8'h00; m_valid = 1'b0; m_ret = 8'd0; m_step_prev = 1'b1;
    end else begin
      if (!m_valid) begin
        if (!STALL) begin
          m_ir = mem[m_pc];
          m_valid = 1'b1;
        end
      end else if (!STALL && allowed) begin
        m_pc = JUMP_EN ? JUMP_ADDR : 4'((int'(m_pc) + 1) % 16);
        m_ret = 8'((int'(m_ret) + 1) % 256);
        m_valid = 1'b0;
      end
      m_step_prev = STEP;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
  endtask

  task automatic do_reset();
    RST = 1'b1; STALL = 1'b0; JUMP_EN = 1'b0; JUMP_ADDR = 4'h0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    init_mem();
    STEP = 1'b0;
    do_reset();
    total_cnt++; if (PC !== 4'h0) $display("FAIL reset_pc: got %h want 0", PC); else pass_cnt++;
    total_cnt++; if (MEM_ADDR !== 4'h0) $display("FAIL reset_mem_addr: got %h want 0", MEM_ADDR); else pass_cnt++;
    total_cnt++; if (IR !== 8'h00) $display("FAIL reset_ir: got %h want 00", IR); else pass_cnt++;
    total_cnt++; if (IR_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", IR_VALID); else pass_cnt++;
    total_cnt++; if (RETIRED !== 8'd0) $display("FAIL reset_retired: got %0d want 0", RETIRED); else pass_cnt++;
  endtask

  task automatic test_sequential();
    init_mem();
    do_reset();
    for (int i = 0; i < 34; i++) begin
      total_cnt++;
      if (MEM_ADDR !== 4'((i / 2) % 16)) $display("FAIL seq_addr[%0d]: got %h want %h", i, MEM_ADDR, 4'((i / 2) % 16));
      else pass_cnt++;
      total_cnt++;
      if (IR_VALID !== 1'(i % 2)) $display("FAIL seq_valid[%0d]: got %b want %b", i, IR_VALID, 1'(i % 2));
      else pass_cnt++;
      if (i % 2 == 1) begin
        total_cnt++;
        if (IR !== 8'h30 + 8'((i / 2) % 16)) $display("FAIL seq_ir[%0d]: got %h want %h", i, IR, 8'h30 + 8'((i / 2) % 16));
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++; if (RETIRED !== 8'd17) $display("FAIL seq_retired: got %0d want 17", RETIRED); else pass_cnt++;
    total_cnt++; if (PC !== 4'h1) $display("FAIL seq_wrap_pc: got %h want 1", PC); else pass_cnt++;
  endtask

  task automatic test_jump();
    init_mem();
    do_reset();
    repeat (7) tick();
    total_cnt++; if (PC !== 4'h3 || IR_VALID !== 1'b1) $display("FAIL jump_setup: got pc %h valid %b want 3 1", PC, IR_VALID); else pass_cnt++;
    JUMP_EN = 1'b1; JUMP_ADDR = 4'hA;
    tick();
    JUMP_EN = 1'b0;
    total_cnt++; if (MEM_ADDR !== 4'hA) $display("FAIL jump_addr: got %h want A", MEM_ADDR); else pass_cnt++;
    total_cnt++; if (RETIRED !== 8'd4) $display("FAIL jump_retired: got %0d want 4", RETIRED); else pass_cnt++;
    tick();
    total_cnt++; if (IR !== 8'h3A || IR_VALID !== 1'b1) $display("FAIL jump_ir: got %h/%b want 3A/1", IR, IR_VALID); else pass_cnt++;
    // jump request during fetch must be ignored
    do_reset();
    repeat (6) tick();
    JUMP_EN = 1'b1; JUMP_ADDR = 4'hA;
    tick();
    JUMP_EN = 1'b0;
    total_cnt++; if (PC !== 4'h3) $display("FAIL jump_fetch_hold: got %h want 3", PC); else pass_cnt++;
    tick();
    total_cnt++; if (PC !== 4'h4) $display("FAIL jump_fetch_ignored: got %h want 4", PC); else pass_cnt++;
  endtask

  task automatic test_stall();
    init_mem();
    do_reset();
    repeat (11) tick();
    STALL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      JUMP_EN = 1'(i % 2); JUMP_ADDR = 4'($urandom_range(0, 15));
      tick();
      total_cnt++;
      if (IR !== 8'h35 || PC !== 4'h5 || IR_VALID !== 1'b1 || RETIRED !== 8'd5)
        $display("FAIL stall_hold[%0d]: got ir %h pc %h valid %b ret %0d want 35 5 1 5", i, IR, PC, IR_VALID, RETIRED);
      else pass_cnt++;
    end
    STALL = 1'b0; JUMP_EN = 1'b0;
    tick();
    total_cnt++; if (PC !== 4'h6 || RETIRED !== 8'd6) $display("FAIL stall_release: got pc %h ret %0d want 6 6", PC, RETIRED); else pass_cnt++;
  endtask

  task automatic test_reset_mid_exec();
    init_mem();
    do_reset();
    repeat (19) tick();
    total_cnt++; if (PC !== 4'h9 || IR_VALID !== 1'b1) $display("FAIL rst_setup: got pc %h valid %b want 9 1", PC, IR_VALID); else pass_cnt++;
    RST = 1'b1; JUMP_EN = 1'b1; JUMP_ADDR = 4'h3;
    tick();
    RST = 1'b0; JUMP_EN = 1'b0;
    total_cnt++;
    if (PC !== 4'h0 || IR !== 8'h00 || IR_VALID !== 1'b0 || RETIRED !== 8'd0)
      $display("FAIL rst_mid_exec: got pc %h ir %h valid %b ret %0d want 0 00 0 0", PC, IR, IR_VALID, RETIRED);
    else pass_cnt++;
    repeat (3) tick();
    STALL = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0; STALL = 1'b0;
    total_cnt++;
    if (PC !== 4'h0 || IR !== 8'h00 || IR_VALID !== 1'b0 || RETIRED !== 8'd0)
      $display("FAIL rst_with_stall: got pc %h ir %h valid %b ret %0d want 0 00 0 0", PC, IR, IR_VALID, RETIRED);
    else pass_cnt++;
  endtask

  task automatic test_self_jump();
    logic [7:0] v;
    init_mem();
    do_reset();
    repeat (15) tick();
    for (int i = 0; i < 4; i++) begin
      JUMP_EN = 1'b1; JUMP_ADDR = 4'h7;
      tick();
      JUMP_EN = 1'b0;
      v = 8'hC0 + 8'(i);
      mem[7] = v;
      tick();
      total_cnt++;
      if (PC !== 4'h7 || IR !== v || IR_VALID !== 1'b1)
        $display("FAIL self_jump[%0d]: got pc %h ir %h valid %b want 7 %h 1", i, PC, IR, IR_VALID, v);
      else pass_cnt++;
    end
    total_cnt++; if (RETIRED !== 8'd11) $display("FAIL self_jump_retired: got %0d want 11", RETIRED); else pass_cnt++;
  endtask

`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
  task automatic test_single_step();
    init_mem();
    STEP = 1'b0;
    do_reset();
    tick();
    STEP = 1'b1;
    repeat (10) tick();
    STEP = 1'b0;
    total_cnt++; if (RETIRED !== 8'd1) $display("FAIL step_held: got %0d want 1", RETIRED); else pass_cnt++;
    // held through reset
    STEP = 1'b1;
    do_reset();
    repeat (3) tick();
    total_cnt++; if (RETIRED !== 8'd0 || IR_VALID !== 1'b1) $display("FAIL step_through_reset: got ret %0d valid %b want 0 1", RETIRED, IR_VALID); else pass_cnt++;
    STEP = 1'b0;
    tick();
    total_cnt++; if (RETIRED !== 8'd0) $display("FAIL step_release: got %0d want 0", RETIRED); else pass_cnt++;
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    total_cnt++; if (RETIRED !== 8'd1) $display("FAIL step_repress: got %0d want 1", RETIRED); else pass_cnt++;
    // pulse during fetch is lost
    do_reset();
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    tick();
    tick();
    total_cnt++; if (RETIRED !== 8'd0 || IR_VALID !== 1'b1) $display("FAIL step_in_fetch: got ret %0d valid %b want 0 1", RETIRED, IR_VALID); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    STEP = 1'b0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      STALL     = ($urandom_range(0, 3) == 0);
      JUMP_EN   = ($urandom_range(0, 2) == 0);
      JUMP_ADDR = 4'($urandom_range(0, 15));
      STEP      = 1'($urandom_range(0, 1));
      RST       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 15)] = 8'($urandom);
      tick();
      total_cnt++;
      if (PC !== m_pc || MEM_ADDR !== m_pc || IR !== m_ir || IR_VALID !== m_valid || RETIRED !== m_ret)
        $display("FAIL random[%0d]: got pc %h addr %h ir %h valid %b ret %0d want pc %h ir %h valid %b ret %0d",
                 n, PC, MEM_ADDR, IR, IR_VALID, RETIRED, m_pc, m_ir, m_valid, m_ret);
      else pass_cnt++;
    end
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; JUMP_EN = 1'b0; JUMP_ADDR = 4'h0; STEP = 1'b0;
    m_pc = 4'h0; m_ir = 8'h00; m_valid = 1'b0; m_ret = 8'd0;
    init_mem();
    #1;
    test_reset();
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
    test_single_step();
`else
    test_sequential();
    test_jump();
    test_stall();
    test_reset_mid_exec();
    test_self_jump();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of ProgramMemory.
- Owns the 4-bit program counter and drives the memory address.
- Latches the returned 8-bit instruction into an instruction register and presents it to the decode/execute logic with a valid flag.
- Accepts jump requests (JMP/JNC resolution) from execute and counts retired instructions.

Parameters:
- RETIRE_W, 8, width of retired-instruction counter
- RESET_PC, 4'h0, PC value loaded on reset

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  reset; synchronous, active-high
- MEM_ADDR  output  4  address to ProgramMemory A; always equals PC
- MEM_DATA  input  8  instruction from ProgramMemory D; combinational from MEM_ADDR
- STALL  input  1  hold current state; no PC/IR/counter change
- JUMP_EN  input  1  execute requests PC load; sampled only on the EXEC completion cycle
- JUMP_ADDR  input  4  jump target
- IR  output  8  instruction register
- IR_VALID  output  1  IR holds an instruction awaiting execution
- PC  output  4  current program counter
- RETIRED  output  RETIRE_W  count of completed EXEC cycles, wraps

Behaviour:
- Reset: CLK and RST only; RST is synchronous, active-high. On a clock edge with RST=1: PC=RESET_PC, IR=8'h00, IR_VALID=0, RETIRED=0, state=S_FETCH. RST overrides STALL, JUMP_EN and STEP. Asserting RST mid-EXEC discards the in-flight instruction (no retire, no jump).
- FSM, two states:
  - S_FETCH: MEM_ADDR=PC; IR_VALID=0. On an edge with STALL=0: IR<=MEM_DATA, state<=S_EXEC. With STALL=1: hold.
  - S_EXEC: IR_VALID=1; IR stable. The completion cycle is STALL=0 (and step condition, see Optional Feature). On completion:
    - PC<=JUMP_ADDR if JUMP_EN=1, else PC+1 mod 16 (4'hF -> 4'h0).
    - RETIRED<=RETIRED+1 mod 2^RETIRE_W.
    - state<=S_FETCH.
  - Not completing: hold everything, IR_VALID stays 1.
- JUMP_EN/JUMP_ADDR are ignored in S_FETCH and on non-completing EXEC cycles.
- Jump to the current PC (self-loop) is legal: PC unchanged, instruction refetched.
- Throughput: one instruction per 2 cycles with STALL=0.
- Latency: first IR_VALID=1 in the 2nd cycle after RST deasserts (cycle 0 fetch, cycle 1 exec).
- MEM_ADDR and PC are registered-PC outputs; no combinational path from JUMP_* to MEM_ADDR.
- MEM_DATA is sampled only at the S_FETCH->S_EXEC edge; changes at other times have no effect.

Optional Feature:
- Macro: INSTRUCTION_FETCH_SINGLE_STEP_EN.
- Defined:
  - Adds port STEP input 1 (debug step button, already synchronised).
  - Internal register detects the STEP rising edge: step_pulse = STEP & ~STEP_q.
  - STEP_q resets to 1, so a STEP held high through reset does not step.
  - EXEC completes only when STALL=0 and step_pulse=1. A pulse arriving during S_FETCH or under STALL is lost, not queued.
  - S_FETCH behaviour is unchanged.
- Undefined: STEP port absent; EXEC completes whenever STALL=0.

Test Plan:
- Reset, memory returns 8'h30+addr, STALL=0, JUMP_EN=0 for 34 cycles -> MEM_ADDR sequence 0,0,1,1,...,F,F,0,0; IR at each valid = 8'h30+PC; RETIRED=17 after 34 cycles; PC wraps F->0.
- In EXEC at PC=3, JUMP_EN=1, JUMP_ADDR=4'hA -> next MEM_ADDR=A, IR=MEM[A], RETIRED+1. JUMP_EN=1 during S_FETCH -> ignored, PC stays 3->4 normally.
- STALL=1 for 5 cycles starting in EXEC at PC=5 -> IR, PC=5, IR_VALID=1, RETIRED all frozen; JUMP_EN pulses during the stall are ignored. After release, a single completion -> PC=6.
- RST=1 asserted in EXEC at PC=9 with JUMP_EN=1 -> next edge PC=0, IR=0, IR_VALID=0, RETIRED=0. RST=1 with STALL=1 still resets.
- Self-jump JUMP_ADDR=PC=7 repeated 4 times -> PC stays 7, RETIRED increments by 4, IR refetched each time.
- With INSTRUCTION_FETCH_SINGLE_STEP_EN, STEP held high 10 cycles -> exactly one retire. STEP held high through reset, then released and re-pressed -> first retire only on the re-press. STEP pulsed during S_FETCH -> no retire.
